// File: rtl/ball_motion_ctrl_pkg.sv
// Shared types and helpers for the tilt-driven ball motion engine.
package ball_motion_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_X,
    WAIT_X,
    CHK_Y,
    WAIT_Y,
    COMMIT
  } state_t;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // |tilt| limited to the largest positive value of a width-bit signed number
  function automatic int unsigned sat_abs(input int tilt, input int width);
    int unsigned lim;
    int unsigned m;
    lim = (32'd1 << (width - 1)) - 32'd1;
    m   = (tilt < 0) ? unsigned'(-tilt) : unsigned'(tilt);
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Map lookup handshake: candidate cell request and wall/ack response.
interface ball_motion_ctrl_if #(
  parameter int POS_W = 8
) ();
  logic             map_req;
  logic [POS_W-1:0] map_x;
  logic [POS_W-1:0] map_y;
  logic             map_ack;
  logic             map_blocked;

  modport master (output map_req, map_x, map_y, input map_ack, map_blocked);
  modport slave  (input map_req, map_x, map_y, output map_ack, map_blocked);
endinterface

// File: rtl/ball_motion_ctrl_tilt_rate_accum.sv
// One axis: tilt -> deadzoned magnitude -> phase accumulator -> pending step with latched direction.
module tilt_rate_accum
  import ball_motion_ctrl_pkg::*;
#(
  parameter int TILT_W   = 8,
  parameter int ACC_W    = 16,
  parameter int STEP_TOP = 40000,
  parameter int DEADZONE = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clr,
  input  logic signed [TILT_W-1:0] tilt,
  output logic                     pend,
  output logic                     dir
);

  int unsigned       abs_v;
  logic [TILT_W-1:0] mag;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic              sgn;
  logic              last_sgn;

  always_comb begin
    abs_v = sat_abs(int'(tilt), TILT_W);
    mag   = (abs_v <= unsigned'(DEADZONE)) ? '0 : TILT_W'(abs_v);
    sum   = acc + ACC_W'(mag);
    sgn   = tilt[TILT_W-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      pend     <= 1'b0;
      dir      <= DIR_POS;
      last_sgn <= DIR_POS;
    end else begin
      if (clr) begin
        pend <= 1'b0;
      end
      // A reversal or a centred stick discards residual phase so the ball never drifts
      if (enable && !pend) begin
        if (mag == '0) begin
          acc <= '0;
        end else if (sgn != last_sgn) begin
          acc      <= '0;
          last_sgn <= sgn;
        end else if (sum >= ACC_W'(STEP_TOP)) begin
          acc  <= sum - ACC_W'(STEP_TOP);
          pend <= 1'b1;
          dir  <= sgn;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position engine: serves per-axis step requests (X before Y) through a map lookup,
// clamping to the field and committing the new cell the cycle after map_ack.
module ball_motion_ctrl
  import ball_motion_ctrl_pkg::*;
#(
  parameter int POS_W    = 8,
  parameter int TILT_W   = 8,
  parameter int ACC_W    = 16,
  parameter int STEP_TOP = 40000,
  parameter int DEADZONE = 4,
  parameter int X_MAX    = 15,
  parameter int Y_MAX    = 15,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [TILT_W-1:0] tilt_x,
  input  logic signed [TILT_W-1:0] tilt_y,
  ball_motion_ctrl_if.master       map_if,
  output logic [POS_W-1:0]         x_out,
  output logic [POS_W-1:0]         y_out,
  output logic                     moved,
  output logic                     bump,
  output logic                     busy
);

  state_t           state, state_nxt;
  logic             pend_x, pend_y, dir_x, dir_y;
  logic             clr_x, clr_y, upd_x, upd_y, set_bump;
  logic             oob_x, oob_y;
  logic [POS_W-1:0] cand_x, cand_y;

  tilt_rate_accum #(
    .TILT_W(TILT_W), .ACC_W(ACC_W), .STEP_TOP(STEP_TOP), .DEADZONE(DEADZONE)
  ) u_acc_x (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr_x),
    .tilt(tilt_x), .pend(pend_x), .dir(dir_x)
  );

  tilt_rate_accum #(
    .TILT_W(TILT_W), .ACC_W(ACC_W), .STEP_TOP(STEP_TOP), .DEADZONE(DEADZONE)
  ) u_acc_y (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr_y),
    .tilt(tilt_y), .pend(pend_y), .dir(dir_y)
  );

  assign cand_x = (dir_x == DIR_NEG) ? x_out - POS_W'(1) : x_out + POS_W'(1);
  assign cand_y = (dir_y == DIR_NEG) ? y_out - POS_W'(1) : y_out + POS_W'(1);
  assign oob_x  = (dir_x == DIR_NEG) ? (x_out == '0) : (x_out >= POS_W'(X_MAX));
  assign oob_y  = (dir_y == DIR_NEG) ? (y_out == '0) : (y_out >= POS_W'(Y_MAX));

  always_comb begin
    state_nxt          = state;
    map_if.map_req     = 1'b0;
    map_if.map_x       = x_out;
    map_if.map_y       = y_out;
    clr_x              = 1'b0;
    clr_y              = 1'b0;
    upd_x              = 1'b0;
    upd_y              = 1'b0;
    set_bump           = 1'b0;
    case (state)
      IDLE: begin
        if (pend_x) begin
          state_nxt = CHK_X;
        end else if (pend_y) begin
          state_nxt = CHK_Y;
        end
      end
      CHK_X, WAIT_X: begin
        if (state == CHK_X && oob_x) begin
          set_bump  = 1'b1;
          clr_x     = 1'b1;
          state_nxt = pend_y ? CHK_Y : COMMIT;
        end else begin
          map_if.map_req = 1'b1;
          map_if.map_x   = cand_x;
          if (map_if.map_ack) begin
            clr_x     = 1'b1;
            set_bump  = map_if.map_blocked;
            upd_x     = !map_if.map_blocked;
            state_nxt = pend_y ? CHK_Y : COMMIT;
          end else begin
            state_nxt = WAIT_X;
          end
        end
      end
      // Y candidate is formed from the already-updated x_out, which lets the ball slide along walls
      CHK_Y, WAIT_Y: begin
        if (state == CHK_Y && oob_y) begin
          set_bump  = 1'b1;
          clr_y     = 1'b1;
          state_nxt = COMMIT;
        end else begin
          map_if.map_req = 1'b1;
          map_if.map_y   = cand_y;
          if (map_if.map_ack) begin
            clr_y     = 1'b1;
            set_bump  = map_if.map_blocked;
            upd_y     = !map_if.map_blocked;
            state_nxt = COMMIT;
          end else begin
            state_nxt = WAIT_Y;
          end
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      x_out <= POS_W'(X_INIT);
      y_out <= POS_W'(Y_INIT);
      moved <= 1'b0;
      bump  <= 1'b0;
    end else begin
      state <= state_nxt;
      moved <= upd_x | upd_y;
      bump  <= set_bump;
      if (upd_x) begin
        x_out <= cand_x;
      end
      if (upd_y) begin
        y_out <= cand_y;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench: single-accumulation enable pulses drive an arithmetic model; a monitor checks every moved/bump.
module tb_ball_motion_ctrl;

  localparam int STEP = 100;
  localparam int MAXC = 15;

  typedef struct {
    bit is_bump;
    int x;
    int y;
  } ev_t;

  logic              clk;
  logic              reset;
  logic              enable;
  logic signed [7:0] tilt_x;
  logic signed [7:0] tilt_y;
  logic [7:0]        x_out, y_out;
  logic              moved, bump, busy;

  ball_motion_ctrl_if #(.POS_W(8)) mif ();

  ball_motion_ctrl #(.STEP_TOP(STEP)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .tilt_x(tilt_x), .tilt_y(tilt_y), .map_if(mif),
    .x_out(x_out), .y_out(y_out), .moved(moved), .bump(bump), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];
  bit  maze[16][16];
  int  acc[2];
  int  last_s[2];
  int  mx, my;
  int  exp_lookups = 0;
  int  lookups     = 0;
  bit  ack_hold    = 0;
  int  ack_max     = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Model: one accumulation of the stick on one axis; returns -1/0/+1 step
  function automatic int mag_of(input int t);
    int m;
    m = (t < 0) ? -t : t;
    if (m > 127) m = 127;
    if (m <= 4) m = 0;
    return m;
  endfunction

  task automatic model_axis(input int ax, input int t, output int step);
    int m, s;
    m = mag_of(t);
    s = (t < 0) ? 1 : 0;
    step = 0;
    if (m == 0) begin
      acc[ax] = 0;
    end else if (s != last_s[ax]) begin
      acc[ax] = 0;
      last_s[ax] = s;
    end else begin
      acc[ax] += m;
      if (acc[ax] >= STEP) begin
        acc[ax] -= STEP;
        step = s ? -1 : 1;
      end
    end
  endtask

  task automatic model_resolve(input int ax, input int step);
    int nx, ny;
    ev_t e;
    if (step == 0) return;
    nx = mx + ((ax == 0) ? step : 0);
    ny = my + ((ax == 1) ? step : 0);
    if (nx < 0 || nx > MAXC || ny < 0 || ny > MAXC) begin
      e.is_bump = 1'b1;
    end else begin
      exp_lookups++;
      if (maze[ny][nx]) begin
        e.is_bump = 1'b1;
      end else begin
        e.is_bump = 1'b0;
        mx = nx;
        my = ny;
      end
    end
    e.x = mx;
    e.y = my;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    acc[0] = 0; acc[1] = 0;
    last_s[0] = 0; last_s[1] = 0;
    mx = 0; my = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    check("idle", int'(busy), 0);
  endtask

  task automatic pulse(input int tx, input int ty);
    int sx, sy;
    model_axis(0, tx, sx);
    model_axis(1, ty, sy);
    model_resolve(0, sx);
    model_resolve(1, sy);
    tilt_x = 8'(tx);
    tilt_y = 8'(ty);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_idle();
  endtask

  // Map responder: random ack delay, checks request stability and commit timing
  initial begin
    bit       in_req, chk_commit;
    int       dly;
    int       rq_x, rq_y;
    in_req = 0; chk_commit = 0; dly = 0; rq_x = 0; rq_y = 0;
    mif.map_ack = 1'b0;
    mif.map_blocked = 1'b0;
    forever begin
      @(negedge clk);
      mif.map_ack = 1'b0;
      mif.map_blocked = 1'b0;
      if (chk_commit) begin
        chk_commit = 0;
        check("commit_after_ack", int'(moved | bump), 1);
      end
      if (!reset || ack_hold) begin
        in_req = 0;
      end else if (mif.map_req) begin
        if (!in_req) begin
          in_req = 1;
          rq_x = int'(mif.map_x);
          rq_y = int'(mif.map_y);
          dly = $urandom_range(0, ack_max);
          lookups++;
        end else begin
          check("req_stable", int'({mif.map_x, mif.map_y}), (rq_x << 8) | rq_y);
        end
        if (dly == 0) begin
          mif.map_ack = 1'b1;
          mif.map_blocked = (rq_x <= MAXC && rq_y <= MAXC) ? maze[rq_y][rq_x] : 1'b0;
          in_req = 0;
          chk_commit = 1;
        end else begin
          dly--;
        end
      end else if (in_req) begin
        check("req_held", 0, 1);
        in_req = 0;
      end
    end
  end

  // Monitor: every moved/bump pulse consumes one expected event
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset && (moved || bump)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ev_bump", int'(bump), int'(e.is_bump));
          check("ev_x", int'(x_out), e.x);
          check("ev_y", int'(y_out), e.y);
        end
      end
    end
  end

  initial begin
    int tx, ty, snap, n;
    reset = 1'b0; enable = 1'b0; tilt_x = '0; tilt_y = '0;
    foreach (maze[i, j]) maze[i][j] = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_req", int'(mif.map_req), 0);
    check("rst_moved", int'(moved), 0);
    check("rst_bump", int'(bump), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    @(negedge clk);

    // Rate: +50 against a threshold of 100 steps every second accumulation
    for (int i = 0; i < 8; i++) pulse(50, 0);
    check("rate_x", int'(x_out), 4);

    // Deadzone: continuous enable with sub-threshold tilt
    snap = lookups;
    tilt_x = 8'sd3; tilt_y = '0; enable = 1'b1;
    repeat (1000) @(negedge clk);
    enable = 1'b0;
    model_axis(0, 3, tx);
    model_axis(1, 0, ty);
    check("dz_lookups", lookups - snap, 0);
    check("dz_x", int'(x_out), 4);

    // Right bound: walk to 15, then further pushes bump without lookups
    for (int i = 0; i < 11; i++) pulse(100, 0);
    check("bound_x", int'(x_out), 15);
    snap = lookups;
    for (int i = 0; i < 3; i++) pulse(100, 0);
    check("bound_lookups", lookups - snap, 0);
    check("bound_x_hold", int'(x_out), 15);

    // Wall on the X candidate only: X bumps, Y still moves
    ack_max = 5;
    maze[0][14] = 1'b1;
    pulse(-100, 0);
    pulse(-100, 100);
    check("slide_x", int'(x_out), 15);
    check("slide_y", int'(y_out), 1);

    // Random maze and tilts
    foreach (maze[i, j]) maze[i][j] = ($urandom_range(0, 3) == 0);
    tx = 0; ty = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) tx = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 2) == 0) ty = int'($urandom_range(0, 255)) - 128;
      pulse(tx, ty);
    end
    check("rand_x", int'(x_out), mx);
    check("rand_y", int'(y_out), my);
    check("lookups", lookups, exp_lookups);
    check("queue_empty", exp_q.size(), 0);

    // Reset while a lookup is outstanding
    ack_hold = 1'b1;
    tilt_x = (mx < 8) ? 8'sd100 : -8'sd100;
    tilt_y = '0;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mif.map_req && n < 20);
    enable = 1'b0;
    check("hold_req_seen", int'(mif.map_req), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_x", int'(x_out), 0);
    check("arst_y", int'(y_out), 0);
    check("arst_req", int'(mif.map_req), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_moved", int'(moved | bump), 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ack_hold = 1'b0;
    tilt_x = '0;
    repeat (20) @(negedge clk);
    check("post_rst_x", int'(x_out), 0);
    check("post_rst_y", int'(y_out), 0);
    check("post_rst_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
